bf_pass_sequencer: RTL and testbench

- Top-level scheduler for the Bellman-Ford relaxation datapath.
- Initialises the distance table in OutputMemory: 16'hFFFF everywhere, 0 at the source vertex.
- Issues edge indices to the relax unit over a valid/ready handshake with bounded outstanding requests.
- Counts passes, runs the final negative-cycle check pass, then raises the Finish and NegCycle flags.

---
 rtl/bf_pass_sequencer_if.sv | 21 ++
 rtl/bf_pass_sequencer.sv | 159 +++++++++++++++
 tb/tb_bf_pass_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_pass_sequencer_if.sv
// Edge issue/completion handshake between the Bellman-Ford pass sequencer
// (master) and the relax unit (slave).
interface bf_pass_sequencer_if #(
  parameter int ADDR_W = 13
);
  logic              edge_valid;
  logic [ADDR_W-1:0] edge_idx;
  logic              edge_ready;
  logic              cmpl;
  logic              cmpl_upd;

  modport master (
    output edge_valid, edge_idx,
    input  edge_ready, cmpl, cmpl_upd
  );

  modport slave (
    input  edge_valid, edge_idx,
    output edge_ready, cmpl, cmpl_upd
  );
endinterface

// File: rtl/bf_pass_sequencer.sv
// Bellman-Ford pass scheduler: distance-table init, bounded edge issue, pass counting.
// Build option BF_EARLY_EXIT_EN: finish as soon as a RELAX pass lowers no distance.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | writing all-ones (0 at src) to OutputMemory, one address per cycle
// RELAX | relaxation pass pass_cnt, 0..V-2
// CHECK | extra pass V-1; any update means a negative cycle
// DONE  | flags held until the next start
module bf_pass_sequencer #(
  parameter int ADDR_W  = 13,
  parameter int DIST_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   num_vertices,
  input  logic [ADDR_W-1:0]   num_edges,
  input  logic [ADDR_W-1:0]   src,
  output logic [ADDR_W-1:0]   OMWAR,
  output logic [DIST_W-1:0]   OMWDR,
  output logic                OMWE,
  bf_pass_sequencer_if.master edge_if,
  output logic                busy,
  output logic [ADDR_W-1:0]   pass_cnt,
  output logic                Finish,
  output logic                NegCycle,
  output logic                err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RELAX = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int               OUT_W     = 4;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_issued;
  logic [OUT_W-1:0]  r_out;
  logic              r_upd_seen;
  logic [ADDR_W-1:0] r_pass_cnt;
  logic              r_finish;
  logic              r_negcycle;
  logic              r_err;

  logic              w_in_pass;
  logic              w_more;
  logic              w_valid;
  logic              w_xfer;
  logic              w_dec;
  logic [OUT_W-1:0]  w_out_nxt;
  logic              w_upd_nxt;
  logic              w_eop;
  logic              w_last_init;

  assign w_in_pass = (r_state == S_RELAX) || (r_state == S_CHECK);
  assign w_more    = r_issued < num_edges;
  assign w_valid   = w_in_pass && w_more && (r_out < MAX_OUT_C);
  assign w_xfer    = w_valid && edge_if.edge_ready;
  // A completion with nothing outstanding only counts if it pairs with this cycle's transfer.
  assign w_dec     = w_in_pass && edge_if.cmpl && ((r_out != '0) || w_xfer);
  assign w_out_nxt = r_out + OUT_W'(w_xfer) - OUT_W'(w_dec);
  assign w_upd_nxt = r_upd_seen | (w_in_pass & edge_if.cmpl & edge_if.cmpl_upd);
  assign w_eop     = w_in_pass && !w_more && (w_out_nxt == '0);
  assign w_last_init = (r_addr == num_vertices - ADDR_W'(1));

  assign edge_if.edge_valid = w_valid;
  assign edge_if.edge_idx   = (w_in_pass && w_more) ? r_issued : '0;

  assign OMWE     = (r_state == S_INIT);
  assign OMWAR    = OMWE ? r_addr : '0;
  assign OMWDR    = (OMWE && (r_addr != src)) ? {DIST_W{1'b1}} : '0;
  assign busy     = (r_state == S_INIT) || w_in_pass;
  assign pass_cnt = r_pass_cnt;
  assign Finish   = r_finish;
  assign NegCycle = r_negcycle;
  assign err      = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_issued   <= '0;
      r_out      <= '0;
      r_upd_seen <= 1'b0;
      r_pass_cnt <= '0;
      r_finish   <= 1'b0;
      r_negcycle <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_finish   <= 1'b0;
            r_negcycle <= 1'b0;
            r_pass_cnt <= '0;
            r_addr     <= '0;
            // src >= V also covers V == 0
            if (src >= num_vertices) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (w_last_init) begin
            r_addr <= '0;
            if ((num_edges == '0) || (num_vertices == ADDR_W'(1))) begin
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_issued   <= '0;
              r_out      <= '0;
              r_upd_seen <= 1'b0;
              r_pass_cnt <= '0;
              r_state    <= S_RELAX;
            end
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_RELAX, S_CHECK: begin
          r_out      <= w_out_nxt;
          r_issued   <= r_issued + ADDR_W'(w_xfer);
          r_upd_seen <= w_upd_nxt;
          if (w_eop) begin
            r_issued   <= '0;
            r_upd_seen <= 1'b0;
            if (r_state == S_CHECK) begin
              r_negcycle <= w_upd_nxt;
              r_finish   <= 1'b1;
              r_state    <= S_DONE;
            end
`ifdef BF_EARLY_EXIT_EN
            else if (!w_upd_nxt) begin
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end
`endif
            else begin
              r_pass_cnt <= r_pass_cnt + ADDR_W'(1);
              if (r_pass_cnt == num_vertices - ADDR_W'(2)) r_state <= S_CHECK;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_pass_sequencer.sv
// Directed bench for bf_pass_sequencer with a small relax-unit model
// (fixed 2-cycle completion latency, or completions driven by hand).
module tb_bf_pass_sequencer;
  localparam int ADDR_W  = 13;
  localparam int DIST_W  = 16;
  localparam int MAX_OUT = 4;

`ifdef BF_EARLY_EXIT_EN
  localparam int A_PASS = 0;
  localparam int A_XFER = 3;
`else
  localparam int A_PASS = 3;
  localparam int A_XFER = 12;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] num_vertices;
  logic [ADDR_W-1:0] num_edges;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] OMWAR;
  logic [DIST_W-1:0] OMWDR;
  logic              OMWE;
  logic              busy;
  logic [ADDR_W-1:0] pass_cnt;
  logic              Finish;
  logic              NegCycle;
  logic              err;

  bf_pass_sequencer_if #(.ADDR_W(ADDR_W)) eif ();

  bf_pass_sequencer #(.ADDR_W(ADDR_W), .DIST_W(DIST_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .num_vertices(num_vertices), .num_edges(num_edges), .src(src),
    .OMWAR(OMWAR), .OMWDR(OMWDR), .OMWE(OMWE),
    .edge_if(eif),
    .busy(busy), .pass_cnt(pass_cnt),
    .Finish(Finish), .NegCycle(NegCycle), .err(err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Controls written only by the stimulus process
  logic hold;
  logic manual_cmpl;
  logic upd_val;
  int   x_base, w_base, ib_base;

  // Observations written only by the model process
  int                wr_cnt  = 0;
  int                xfer_cnt = 0;
  int                idx_bad = 0;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [DIST_W-1:0] wr_data [64];

  initial begin
    int q[$];
    int cyc;
    cyc = 0;
    eif.cmpl     = 1'b0;
    eif.cmpl_upd = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        q.delete();
        eif.cmpl     = 1'b0;
        eif.cmpl_upd = 1'b0;
      end else begin
        if (OMWE) begin
          wr_addr[wr_cnt % 64] = OMWAR;
          wr_data[wr_cnt % 64] = OMWDR;
          wr_cnt++;
        end
        if (eif.edge_valid && eif.edge_ready) begin
          if (int'(eif.edge_idx) != (xfer_cnt - x_base) % int'(num_edges)) idx_bad++;
          xfer_cnt++;
          if (!hold) q.push_back(cyc + 2);
        end
        eif.cmpl = 1'b0;
        if (hold) eif.cmpl = manual_cmpl;
        else if (q.size() > 0 && q[0] == cyc) begin
          eif.cmpl = 1'b1;
          void'(q.pop_front());
        end
        eif.cmpl_upd = eif.cmpl & upd_val;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input int v, input int e, input int s);
    num_vertices = ADDR_W'(v);
    num_edges    = ADDR_W'(e);
    src          = ADDR_W'(s);
    x_base  = xfer_cnt;
    w_base  = wr_cnt;
    ib_base = idx_bad;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(Finish || err) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, int'(Finish | err), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    num_vertices = '0;
    num_edges    = '0;
    src          = '0;
    eif.edge_ready = 1'b1;
    hold = 1'b0;
    manual_cmpl = 1'b0;
    upd_val = 1'b0;
    x_base = 0; w_base = 0; ib_base = 0;

    #12;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_fin",   int'(Finish), 0);
    chk("rst_neg",   int'(NegCycle), 0);
    chk("rst_err",   int'(err), 0);
    chk("rst_valid", int'(eif.edge_valid), 0);
    chk("rst_omwe",  int'(OMWE), 0);
    chk("rst_pass",  int'(pass_cnt), 0);
    reset = 1'b1;
    tick();

    // A: V=4 src=2 E=3, no updates
    upd_val = 1'b0;
    go(4, 3, 2);
    wait_done("A", 300);
    chk("A_wr_cnt", wr_cnt - w_base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("A_wa%0d", i), int'(wr_addr[(w_base + i) % 64]), i);
      chk($sformatf("A_wd%0d", i), int'(wr_data[(w_base + i) % 64]), (i == 2) ? 0 : 'hFFFF);
    end
    chk("A_fin",  int'(Finish), 1);
    chk("A_neg",  int'(NegCycle), 0);
    chk("A_pass", int'(pass_cnt), A_PASS);
    chk("A_xfer", xfer_cnt - x_base, A_XFER);
    chk("A_idx",  idx_bad - ib_base, 0);
    chk("A_busy", int'(busy), 0);

    // B: V=3 E=2, every completion updates
    upd_val = 1'b1;
    go(3, 2, 0);
    chk("B_fin_clr", int'(Finish), 0);
    wait_done("B", 300);
    chk("B_fin",  int'(Finish), 1);
    chk("B_neg",  int'(NegCycle), 1);
    chk("B_pass", int'(pass_cnt), 2);
    chk("B_xfer", xfer_cnt - x_base, 6);
    chk("B_wd0",  int'(wr_data[w_base % 64]), 0);

    // E: src out of range
    go(5, 3, 5);
    chk("E_err",  int'(err), 1);
    chk("E_fin",  int'(Finish), 0);
    chk("E_neg",  int'(NegCycle), 0);
    chk("E_busy", int'(busy), 0);
    tick();
    tick();
    chk("E_wr", wr_cnt - w_base, 0);

    // F: single vertex
    upd_val = 1'b0;
    go(1, 4, 0);
    chk("F_err_clr", int'(err), 0);
    wait_done("F", 50);
    chk("F_fin",  int'(Finish), 1);
    chk("F_neg",  int'(NegCycle), 0);
    chk("F_wr",   wr_cnt - w_base, 1);
    chk("F_wa",   int'(wr_addr[w_base % 64]), 0);
    chk("F_wd",   int'(wr_data[w_base % 64]), 0);
    chk("F_xfer", xfer_cnt - x_base, 0);

    // C: outstanding limit with completions driven by hand
    hold = 1'b1;
    manual_cmpl = 1'b0;
    go(2, 10, 0);
    n = 0;
    while ((xfer_cnt - x_base) < 4 && n < 40) begin tick(); n++; end
    tick(); tick(); tick();
    chk("C_sat_xfer",  xfer_cnt - x_base, 4);
    chk("C_sat_valid", int'(eif.edge_valid), 0);
    manual_cmpl = 1'b1;
    tick();
    chk("C_rel_valid", int'(eif.edge_valid), 1);
    chk("C_rel_idx",   int'(eif.edge_idx), 4);
    tick();
    manual_cmpl = 1'b0;
    chk("C_same_valid", int'(eif.edge_valid), 1);
    chk("C_same_idx",   int'(eif.edge_idx), 5);
    tick();
    chk("C_full_valid", int'(eif.edge_valid), 0);
    chk("C_full_xfer",  xfer_cnt - x_base, 6);
    chk("C_idx",        idx_bad - ib_base, 0);
    reset = 1'b0;
    #1;
    chk("C_abort_busy", int'(busy), 0);
    hold = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // D: ready stall at edge 7, ignored start, async reset mid-CHECK
    upd_val = 1'b1;
    go(2, 12, 1);
    n = 0;
    while ((xfer_cnt - x_base) < 7 && n < 60) begin tick(); n++; end
    eif.edge_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("D_stall_valid%0d", i), int'(eif.edge_valid), 1);
      chk($sformatf("D_stall_idx%0d", i),   int'(eif.edge_idx), 7);
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    eif.edge_ready = 1'b1;
    chk("D_stall_xfer", xfer_cnt - x_base, 7);
    chk("D_start_pass", int'(pass_cnt), 0);
    chk("D_start_busy", int'(busy), 1);
    chk("D_start_omwe", int'(OMWE), 0);
    chk("D_start_wr",   wr_cnt - w_base, 2);
    n = 0;
    while (!(pass_cnt == ADDR_W'(1) && (xfer_cnt - x_base) >= 15) && n < 200) begin tick(); n++; end
    chk("D_in_check", int'(busy && pass_cnt == ADDR_W'(1)), 1);
    chk("D_idx", idx_bad - ib_base, 0);
    reset = 1'b0;
    #1;
    chk("D_rst_busy",  int'(busy), 0);
    chk("D_rst_valid", int'(eif.edge_valid), 0);
    chk("D_rst_pass",  int'(pass_cnt), 0);
    chk("D_rst_fin",   int'(Finish), 0);
    chk("D_rst_neg",   int'(NegCycle), 0);
    chk("D_rst_omwe",  int'(OMWE), 0);
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
